// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encoding and header framing constants.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} loader_state_t;
  localparam int HDR_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian 4-byte assembler shared by header and data words.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q;
  // word exposes the value including the byte accepted this cycle
  always_comb begin
    word  = word_q;
    cnt_d = cnt_q;
    if (clr) begin
      word  = '0;
      cnt_d = '0;
    end else if (en) begin
      word[{cnt_q, 3'b000} +: 8] = din;
      cnt_d = cnt_q + 2'd1;
    end
  end
  assign full = en && !clr && cnt_q == 2'(HDR_BYTES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory and
// holds the core in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int IW = $clog2(DEPTH) + 1;
  loader_state_t state_q, state_d;
  logic [31:0]   n_q, n_d, waddr_q, waddr_d, wdata_q, wdata_d, word;
  logic [IW-1:0] idx_q, idx_d;
  logic          clr, accept, full;
  byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (accept),
    .din  (in_data),
    .word (word),
    .full (full)
  );
  assign in_ready = state_q == HDR || state_q == DATA;
  assign accept   = in_ready && in_valid;
  assign clr      = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign we       = state_q == WRITE;
  assign busy     = in_ready || we;
  assign done     = state_q == DONE;
  assign err      = state_q == ERR;
  assign core_rst = done;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = HDR;
        n_d     = '0;
        idx_d   = '0;
      end
      HDR: if (full) begin
        n_d     = word;
        state_d = word > 32'(DEPTH) ? ERR : word == '0 ? DONE : DATA;
      end
      DATA: if (full) begin
        state_d = WRITE;
        waddr_d = BASE_ADDR + (32'(idx_q) << 2);
        wdata_d = word;
      end
      WRITE: begin
        idx_d   = idx_q + IW'(1);
        state_d = 32'(idx_q) + 32'd1 == n_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard and table-driven checks of the program loader.
module tb_imem_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, we, core_rst, busy, done, err;
  logic [31:0] waddr, wdata;
  int          n_chk = 0, n_fail = 0, n_writes = 0, w0;
  int unsigned next_idx = 0;
  logic [31:0] max_addr = '0;
  logic [63:0] sb[$];
  logic [63:0] e;
  logic        prev_we = 1'b0;

  typedef struct {
    logic [31:0] n;
    logic        exp_done;
    logic        exp_err;
    int          exp_wr;
  } vec_t;
  vec_t tbl[5];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      n_writes++;
      if (waddr > max_addr) max_addr = waddr;
      check("in_ready_in_write", 32'(in_ready), 32'd0);
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, no write expected", waddr, wdata);
      end else begin
        e = sb.pop_front();
        check("waddr", waddr, e[63:32]);
        check("wdata", wdata, e[31:0]);
      end
    end
    prev_we = we;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t == 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 200 cycles, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_data(input logic [31:0] w, input int gap);
    sb.push_back({32'(next_idx * 4), w});
    next_idx++;
    send_word(w, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_load();
    next_idx = 0;
    pulse_start();
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL end_timeout: got done=%0b err=%0b after 20 cycles, required one high", done, err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_waddr"}, waddr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'd0,    1'b1, 1'b0, 0};
    tbl[1] = '{32'd1025, 1'b0, 1'b1, 0};
    tbl[2] = '{32'd1,    1'b1, 1'b0, 1};
    tbl[3] = '{32'd3,    1'b1, 1'b0, 3};
    tbl[4] = '{32'd1024, 1'b1, 1'b0, 1024};

    #2 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // two-word program
    new_load();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_core_rst", 32'(core_rst), 32'd0);
    send_word(32'd2, 0);
    send_data(32'h0050_0113, 0);
    send_data(32'h00A0_0193, 0);
    wait_end();
    check("prog2_done", 32'(done), 32'd1);
    check("prog2_core_rst", 32'(core_rst), 32'd1);
    repeat (3) @(negedge clk);
    check("hold_waddr", waddr, 32'h4);
    check("hold_wdata", wdata, 32'h00A0_0193);

    // empty program: DONE the cycle after the last header byte
    w0 = n_writes;
    new_load();
    send_word(32'd0, 0);
    check("n0_done_next_cycle", 32'(done), 32'd1);
    check("n0_writes", 32'(n_writes - w0), 32'd0);

    // oversize header, then restart
    new_load();
    send_word(32'd1025, 0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_core_rst", 32'(core_rst), 32'd0);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    new_load();
    check("restart_err", 32'(err), 32'd0);
    check("restart_in_ready", 32'(in_ready), 32'd1);
    send_word(32'd0, 0);

    // single word with in_valid toggling
    w0 = n_writes;
    new_load();
    send_word(32'd1, 1);
    send_data(32'hDEAD_BEEF, 1);
    wait_end();
    check("toggle_writes", 32'(n_writes - w0), 32'd1);
    check("toggle_done", 32'(done), 32'd1);

    // reset partway through word 3
    new_load();
    send_word(32'd4, 0);
    send_data(32'h1111_1111, 0);
    send_data(32'h2222_2222, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    check("midreset_sb_empty", 32'(sb.size()), 32'd0);
    new_load();
    send_word(32'd2, 0);
    send_data(32'hCAFE_0001, 0);
    send_data(32'hCAFE_0002, 0);
    wait_end();
    check("reload_done", 32'(done), 32'd1);

    // start ignored in DATA, honoured in DONE
    new_load();
    send_word(32'd3, 0);
    send_data(32'hA5A5_0000, 0);
    pulse_start();
    check("start_in_data_busy", 32'(busy), 32'd1);
    check("start_in_data_ready", 32'(in_ready), 32'd1);
    send_data(32'hA5A5_0001, 0);
    send_data(32'hA5A5_0002, 0);
    wait_end();
    check("ign_done", 32'(done), 32'd1);
    pulse_start();
    check("done_restart_core_rst", 32'(core_rst), 32'd0);
    check("done_restart_hdr", 32'(in_ready), 32'd1);
    check("done_restart_busy", 32'(busy), 32'd1);
    send_word(32'd0, 0);

    // table of header lengths
    for (int k = 0; k < 5; k++) begin
      w0 = n_writes;
      max_addr = '0;
      new_load();
      send_word(tbl[k].n, 0);
      if (!tbl[k].exp_err)
        for (int j = 0; j < int'(tbl[k].n); j++) send_data($urandom, 0);
      wait_end();
      check("tbl_done", 32'(done), 32'(tbl[k].exp_done));
      check("tbl_err", 32'(err), 32'(tbl[k].exp_err));
      check("tbl_core_rst", 32'(core_rst), 32'(tbl[k].exp_done));
      check("tbl_busy", 32'(busy), 32'd0);
      check("tbl_writes", 32'(n_writes - w0), 32'(tbl[k].exp_wr));
      if (k == 4) check("max_waddr", max_addr, 32'(4 * 1023));
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of the first word written.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a program load.
REQ-006 SHALL have port in_valid, input, 1, loader byte stream valid.
REQ-007 SHALL have port in_data, input, 8, loader byte stream data.
REQ-008 SHALL have port in_ready, output, 1, byte accepted on any cycle with in_valid and in_ready both high.
REQ-009 SHALL have port we, output, 1, instruction memory write strobe.
REQ-010 SHALL have port waddr, output, 32, byte address of the write, word-aligned.
REQ-011 SHALL have port wdata, output, 32, write data.
REQ-012 SHALL have port core_rst, output, 1, active-low reset to the core; low while a load is pending or in progress.
REQ-013 SHALL have port busy, done and err, each output, 1: load in progress, load complete, header rejected.

Function
REQ-014 SHALL implement the states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-015 IDLE: on start, SHALL go to HDR and clear the byte counter, word index and word count N.
REQ-016 HDR: SHALL accept 4 bytes little-endian into N[31:0]; after the 4th byte, go to ERR if N > DEPTH, DONE if N == 0, else DATA.
REQ-017 DATA: SHALL accept 4 bytes little-endian into the word register (first byte is [7:0]); after the 4th byte, go to WRITE.
REQ-018 WRITE: SHALL drive we=1 for exactly one cycle, with waddr = BASE_ADDR + 4*idx and wdata equal to the assembled word.
REQ-019 After WRITE, SHALL increment idx and go to DONE if idx+1 == N, else back to DATA.
REQ-020 in_ready SHALL be 1 only in HDR and DATA, and SHALL be combinational from state only, never from in_valid.
REQ-021 in_valid low SHALL stall HDR/DATA indefinitely with no timeout; a partial byte count SHALL be retained.
REQ-022 busy SHALL be 1 in HDR, DATA and WRITE; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-023 core_rst SHALL be 1 only in DONE; core_rst SHALL be 0 in IDLE, HDR, DATA, WRITE and ERR.
REQ-024 start SHALL be ignored in HDR, DATA and WRITE; start in DONE or ERR SHALL restart at HDR, with core_rst dropping to 0 the next cycle.
REQ-025 waddr and wdata SHALL hold their last values when we=0; idx SHALL be wide enough for DEPTH (clog2(DEPTH)+1 bits).
REQ-026 The highest write for N == DEPTH SHALL be BASE_ADDR + 4*(DEPTH-1); waddr SHALL never exceed this value.

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE; in_ready, we, busy, done, err and core_rst at 0; waddr, wdata, N, idx and the byte counter at 0.
REQ-028 Reset mid-load SHALL abort the load without further writes; memory words already written SHALL remain as written.

Structure
REQ-029 The shared package SHALL hold the state enum (loader_state_t) and the header byte count constant (HDR_BYTES = 4).
REQ-030 SHALL contain one sub-module, byte_packer (4-byte little-endian assembler with count and full flag), reused for both the header and the data words.

Verification
REQ-031 Header 02 00 00 00, then words 00500113 and 00A00193 -> we pulses at waddr 0x0 and 0x4 with those words; done=1 and core_rst=1 after the 2nd write.
REQ-032 Header 00 00 00 00 -> no we pulse; DONE is entered the cycle after the 4th header byte.
REQ-033 Header 01 04 00 00 (N=1025) with DEPTH=1024 -> err=1, no writes, core_rst=0; a following start restarts at HDR.
REQ-034 N=1 with in_valid toggling every other cycle -> exactly one write of the correct word; in_ready=0 throughout WRITE.
REQ-035 rst asserted after 2 data bytes of word 3 -> all outputs reset immediately; a new start plus a full stream reloads correctly from 0x0.
REQ-036 start pulsed in DATA -> ignored, with no change to idx or waddr sequence; start in DONE -> core_rst=0 and state HDR.
